// File: rtl/intr_pkg.sv
// -----------------------------------------------------------------------------
// intr_pkg
// Shared definitions for the external interrupt controller:
//   - default source count and priority width
//   - register byte offsets of the claim/complete register port
//   - gateway and notify state encodings
//   - prio_off(): byte offset of the PRIORITY register for a 0-based source index
// -----------------------------------------------------------------------------
package intr_pkg;

    localparam int DEF_NUM_SRC = 8;
    localparam int DEF_PRIO_W  = 3;

    localparam logic [7:0] ENABLE_OFF  = 8'h00;
    localparam logic [7:0] PENDING_OFF = 8'h04;
    localparam logic [7:0] THRESH_OFF  = 8'h08;
    localparam logic [7:0] CLAIM_OFF   = 8'h0C;
    localparam logic [7:0] PRIO_BASE   = 8'h10;

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PEND    = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_e;

    typedef enum logic [1:0] {
        N_IDLE    = 2'd0,
        N_NOTIFY  = 2'd1,
        N_SERVICE = 2'd2
    } notify_state_e;

    // Index 0 is interrupt ID 1.
    function automatic logic [7:0] prio_off(input int idx);
        return PRIO_BASE + 8'(4 * idx);
    endfunction

endpackage

// File: rtl/intr_gateway.sv
// -----------------------------------------------------------------------------
// intr_gateway
// Per-source interrupt gateway: rising-edge detection on the raw line and a
// three-state IDLE -> PEND -> CLAIMED tracker. Edges seen outside IDLE are
// dropped (no counting).
// Optional macro INTR_SYNC_EN: adds a 2-flop synchroniser in front of the
// edge detector.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   src_i          raw interrupt line
//   claim_i        this ID is being claimed this cycle (PEND -> CLAIMED)
//   complete_i     complete written with this ID (CLAIMED -> IDLE)
//   pend_o         source is pending
// -----------------------------------------------------------------------------
module intr_gateway
    import intr_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic pend_o
);

    logic      w_src;
    logic      w_edge;
    logic      r_src_prev;
    gw_state_e r_state;
    gw_state_e w_state_nxt;

`ifdef INTR_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchroniser for an asynchronous peripheral line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= src_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = src_i;
`endif

    // Last-cycle sample of the line for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_src_prev <= 1'b0;
        end else begin
            r_src_prev <= w_src;
        end
    end

    assign w_edge = w_src & ~r_src_prev;

    // Gateway next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            GW_IDLE: begin
                if (w_edge) w_state_nxt = GW_PEND;
                else        w_state_nxt = GW_IDLE;
            end
            GW_PEND: begin
                if (claim_i) w_state_nxt = GW_CLAIMED;
                else         w_state_nxt = GW_PEND;
            end
            GW_CLAIMED: begin
                if (complete_i) w_state_nxt = GW_IDLE;
                else            w_state_nxt = GW_CLAIMED;
            end
            default: w_state_nxt = GW_IDLE;
        endcase
    end

    // Gateway state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= GW_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign pend_o = (r_state == GW_PEND);

endmodule

// File: rtl/ext_intr_ctrl.sv
// -----------------------------------------------------------------------------
// ext_intr_ctrl
// External interrupt controller: per-source gateways, priority arbiter,
// claim/complete register port and a notify FSM driving the core's single
// external interrupt line. Optional macro INTR_SYNC_EN adds input
// synchronisers inside each gateway (edge-to-e_intr_o latency 4 instead of 2).
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   src_i             rising-edge peripheral interrupt lines, bit n-1 = ID n
//   reg_we_i/re_i     register write / read strobes (exclusive)
//   reg_addr_i        byte address; reg_wdata_i write data
//   reg_rdata_o       read data, valid the cycle after reg_re_i
//   is_mret_i         core executing mret (re-arms notification)
//   e_intr_o          one-cycle interrupt request to the core
//   irq_id_o          registered current best eligible ID (debug)
// -----------------------------------------------------------------------------
module ext_intr_ctrl
    import intr_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int PRIO_W  = DEF_PRIO_W,
    parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               reg_we_i,
    input  logic               reg_re_i,
    input  logic [7:0]         reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [31:0]        reg_rdata_o,
    input  logic               is_mret_i,
    output logic               e_intr_o,
    output logic [ID_W-1:0]    irq_id_o
);

    logic [NUM_SRC-1:0] r_enable;
    logic [PRIO_W-1:0]  r_thresh;
    logic [PRIO_W-1:0]  r_prio [NUM_SRC];
    logic [31:0]        r_rdata;
    logic [ID_W-1:0]    r_irq_id;
    logic               r_e_intr;
    notify_state_e      r_nstate;
    notify_state_e      w_nstate_nxt;

    logic [NUM_SRC-1:0] w_pend;
    logic [NUM_SRC-1:0] w_claim;
    logic [NUM_SRC-1:0] w_complete;
    logic               w_claim_rd;
    logic [ID_W-1:0]    w_win_id;
    logic [PRIO_W-1:0]  w_win_prio;
    logic [31:0]        w_rdata;

    assign w_claim_rd = reg_re_i && (reg_addr_i == CLAIM_OFF);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        assign w_claim[g]    = w_claim_rd && (w_win_id == ID_W'(g + 1));
        assign w_complete[g] = reg_we_i && (reg_addr_i == CLAIM_OFF)
                               && (reg_wdata_i == 32'(g + 1));

        intr_gateway u_gw (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .src_i      (src_i[g]),
            .claim_i    (w_claim[g]),
            .complete_i (w_complete[g]),
            .pend_o     (w_pend[g])
        );
    end

    // Arbiter: ascending scan with strict '>' so ties keep the lowest ID;
    // starting from priority 0 means priority-0 sources never win.
    always_comb begin
        w_win_id   = '0;
        w_win_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_pend[i] && r_enable[i] && (r_prio[i] > r_thresh)
                && (r_prio[i] > w_win_prio)) begin
                w_win_id   = ID_W'(i + 1);
                w_win_prio = r_prio[i];
            end else begin
                w_win_id   = w_win_id;
                w_win_prio = w_win_prio;
            end
        end
    end

    // Read data mux; unused upper bits and unmapped addresses read 0.
    always_comb begin
        w_rdata = '0;
        case (reg_addr_i)
            ENABLE_OFF:  w_rdata[NUM_SRC-1:0] = r_enable;
            PENDING_OFF: w_rdata[NUM_SRC-1:0] = w_pend;
            THRESH_OFF:  w_rdata[PRIO_W-1:0]  = r_thresh;
            CLAIM_OFF:   w_rdata[ID_W-1:0]    = w_win_id;
            default: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (reg_addr_i == prio_off(i)) w_rdata[PRIO_W-1:0] = r_prio[i];
                    else                           w_rdata = w_rdata;
                end
            end
        endcase
    end

    // Configuration registers; a same-cycle claim sees the pre-write values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_enable <= '0;
            r_thresh <= '0;
            for (int i = 0; i < NUM_SRC; i++) r_prio[i] <= '0;
        end else if (reg_we_i) begin
            case (reg_addr_i)
                ENABLE_OFF: r_enable <= reg_wdata_i[NUM_SRC-1:0];
                THRESH_OFF: r_thresh <= reg_wdata_i[PRIO_W-1:0];
                default: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (reg_addr_i == prio_off(i)) r_prio[i] <= reg_wdata_i[PRIO_W-1:0];
                        else                           r_prio[i] <= r_prio[i];
                    end
                end
            endcase
        end else begin
            r_enable <= r_enable;
            r_thresh <= r_thresh;
        end
    end

    // Registered read data and debug winner ID.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata  <= '0;
            r_irq_id <= '0;
        end else begin
            if (reg_re_i) r_rdata <= w_rdata;
            else          r_rdata <= r_rdata;
            r_irq_id <= w_win_id;
        end
    end

    // Notify FSM next state; mret is only honoured in SERVICE.
    always_comb begin
        w_nstate_nxt = r_nstate;
        case (r_nstate)
            N_IDLE: begin
                if (w_win_id != '0) w_nstate_nxt = N_NOTIFY;
                else                w_nstate_nxt = N_IDLE;
            end
            N_NOTIFY:  w_nstate_nxt = N_SERVICE;
            N_SERVICE: begin
                if (is_mret_i) w_nstate_nxt = N_IDLE;
                else           w_nstate_nxt = N_SERVICE;
            end
            default: w_nstate_nxt = N_IDLE;
        endcase
    end

    // Notify FSM state register; e_intr_o is registered alongside NOTIFY.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_nstate <= N_IDLE;
            r_e_intr <= 1'b0;
        end else begin
            r_nstate <= w_nstate_nxt;
            r_e_intr <= (w_nstate_nxt == N_NOTIFY);
        end
    end

    assign reg_rdata_o = r_rdata;
    assign irq_id_o    = r_irq_id;
    assign e_intr_o    = r_e_intr;

endmodule

// File: tb/tb_ext_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ext_intr_ctrl
// Directed self-checking bench for ext_intr_ctrl. Expected register read data
// and expected e_intr_o traces are queued when stimulus is driven and popped
// when the DUT output is sampled (1 time unit after the rising clock edge).
// -----------------------------------------------------------------------------
module tb_ext_intr_ctrl;

`ifdef INTR_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  src_i;
    logic        reg_we_i;
    logic        reg_re_i;
    logic [7:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [31:0] reg_rdata_o;
    logic        is_mret_i;
    logic        e_intr_o;
    logic [3:0]  irq_id_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_q[$];
    string       rd_tag_q[$];
    logic        intr_q[$];

    always #5 clk_i = ~clk_i;

    ext_intr_ctrl dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .src_i       (src_i),
        .reg_we_i    (reg_we_i),
        .reg_re_i    (reg_re_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_rdata_o (reg_rdata_o),
        .is_mret_i   (is_mret_i),
        .e_intr_o    (e_intr_o),
        .irq_id_o    (irq_id_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        reg_we_i    = 1'b1;
        reg_addr_i  = a;
        reg_wdata_i = d;
        step();
        reg_we_i    = 1'b0;
    endtask

    task automatic reg_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
        reg_re_i   = 1'b1;
        reg_addr_i = a;
        rd_q.push_back(exp);
        rd_tag_q.push_back(tag);
        step();
        reg_re_i = 1'b0;
        check(rd_tag_q.pop_front(), reg_rdata_o, rd_q.pop_front());
    endtask

    task automatic mret();
        is_mret_i = 1'b1;
        step();
        is_mret_i = 1'b0;
    endtask

    // Drive a one-cycle pulse on 'mask' (0 = just watch) and check e_intr_o
    // for n cycles; it must be high only on cycle hi_at (0 = never).
    task automatic pulse_watch(input logic [7:0] mask, input int n, input int hi_at, input string tag);
        src_i = mask;
        for (int c = 1; c <= n; c++) intr_q.push_back(c == hi_at);
        for (int c = 1; c <= n; c++) begin
            step();
            if (c == 1) src_i = 8'h00;
            check(tag, 32'(e_intr_o), 32'(intr_q.pop_front()));
        end
    endtask

    initial begin
        rst_ni      = 1'b0;
        src_i       = 8'h00;
        reg_we_i    = 1'b0;
        reg_re_i    = 1'b0;
        reg_addr_i  = 8'h00;
        reg_wdata_i = 32'h0;
        is_mret_i   = 1'b0;
        step();
        step();
        check("rst_e_intr", 32'(e_intr_o), 32'h0);
        check("rst_irq_id", 32'(irq_id_o), 32'h0);
        check("rst_rdata", reg_rdata_o, 32'h0);
        rst_ni = 1'b1;
        step();
        reg_read(8'h00, 32'h0, "rst_enable");
        reg_read(8'h04, 32'h0, "rst_pending");

        // Single source, ID3 priority 2
        reg_write(8'h18, 32'h2);
        reg_write(8'h08, 32'h0);
        reg_write(8'h00, 32'hFFFF_FF04);
        reg_read(8'h00, 32'h04, "enable_upper_bits");
        reg_read(8'h18, 32'h2, "prio3_rb");
        pulse_watch(8'h04, LAT + 2, LAT, "single_intr");
        check("single_irq_id", 32'(irq_id_o), 32'h3);
        reg_read(8'h04, 32'h04, "single_pend");
        reg_read(8'h0C, 32'h3, "single_claim");
        reg_read(8'h04, 32'h0, "single_pend_after");
        reg_write(8'h0C, 32'h3);
        mret();

        // Priority and tie-break: ID2=5, ID5=5, ID7=6
        reg_write(8'h14, 32'h5);
        reg_write(8'h20, 32'h5);
        reg_write(8'h28, 32'h6);
        reg_write(8'h00, 32'hFF);
        pulse_watch(8'h52, LAT + 2, LAT, "tie_intr");
        reg_read(8'h0C, 32'h7, "tie_claim_7");
        reg_read(8'h0C, 32'h2, "tie_claim_2");
        reg_read(8'h0C, 32'h5, "tie_claim_5");
        reg_read(8'h0C, 32'h0, "tie_claim_empty");
        reg_write(8'h0C, 32'h7);
        reg_write(8'h0C, 32'h2);
        reg_write(8'h0C, 32'h5);
        mret();
        reg_write(8'h30, 32'hFF);
        reg_read(8'h30, 32'h0, "unmapped_read");

        // Threshold masking: ID4 prio 2, threshold 2
        reg_write(8'h1C, 32'h2);
        reg_write(8'h08, 32'h2);
        pulse_watch(8'h08, LAT + 2, 0, "thresh_masked");
        reg_read(8'h04, 32'h08, "thresh_pend");
        reg_write(8'h08, 32'h1);
        pulse_watch(8'h00, 3, 1, "thresh_lowered");
        reg_read(8'h0C, 32'h4, "thresh_claim");
        reg_write(8'h0C, 32'h4);
        mret();

        // Handshake: ID1 prio 3
        reg_write(8'h10, 32'h3);
        pulse_watch(8'h01, LAT + 2, LAT, "hs_intr1");
        reg_read(8'h0C, 32'h1, "hs_claim1");
        pulse_watch(8'h01, LAT + 2, 0, "hs_dropped");
        reg_read(8'h04, 32'h0, "hs_pend_dropped");
        reg_write(8'h0C, 32'h1);
        mret();
        pulse_watch(8'h00, 3, 0, "hs_no_stale");
        pulse_watch(8'h01, LAT + 2, LAT, "hs_intr2");
        reg_write(8'h0C, 32'h1);
        reg_read(8'h04, 32'h01, "hs_bad_complete");
        reg_read(8'h0C, 32'h1, "hs_claim2");
        reg_write(8'h0C, 32'h1);
        mret();

        // Notify gating: ID2 and ID5 pend together
        pulse_watch(8'h12, LAT + 2, LAT, "gate_intr1");
        reg_read(8'h0C, 32'h2, "gate_claim2");
        pulse_watch(8'h00, 4, 0, "gate_held");
        mret();
        pulse_watch(8'h00, 3, 1, "gate_intr2");
        reg_read(8'h0C, 32'h5, "gate_claim5");
        reg_write(8'h0C, 32'h2);
        reg_write(8'h0C, 32'h5);
        mret();

        // Asynchronous reset in SERVICE with ID1 claimed and ID2 pending
        pulse_watch(8'h01, LAT + 2, LAT, "rst2_intr");
        reg_read(8'h0C, 32'h1, "rst2_claim");
        pulse_watch(8'h02, LAT + 2, 0, "rst2_held");
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst2_e_intr", 32'(e_intr_o), 32'h0);
        check("rst2_irq_id", 32'(irq_id_o), 32'h0);
        check("rst2_rdata", reg_rdata_o, 32'h0);
        step();
        step();
        rst_ni = 1'b1;
        step();
        reg_read(8'h04, 32'h0, "rst2_pending");
        reg_read(8'h00, 32'h0, "rst2_enable");
        reg_read(8'h10, 32'h0, "rst2_prio1");
        reg_read(8'h08, 32'h0, "rst2_thresh");
        reg_read(8'h0C, 32'h0, "rst2_claim_none");
        reg_write(8'h10, 32'h3);
        reg_write(8'h00, 32'h01);
        pulse_watch(8'h00, 4, 0, "rst2_no_edge");
        check("rst2_irq_idle", 32'(irq_id_o), 32'h0);
        pulse_watch(8'h01, LAT + 2, LAT, "rst2_fresh");
        reg_read(8'h0C, 32'h1, "rst2_fresh_claim");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
